nibble_serial_adder: RTL and testbench

Multi-word adder sequencer that reuses the existing 4-bit ripple adder (full_adder4) as its datapath. It accepts two NIBBLES*4-bit operands plus carry-in over a valid/ready handshake. It feeds the adder one nibble per cycle, LSB nibble first, with the carry held in a register between nibbles. It presents the registered sum and carry-out over an output valid/ready handshake.

---
 rtl/nibble_serial_adder_pkg.sv | 14 +
 rtl/full_adder4.sv | 21 ++
 rtl/nibble_serial_adder.sv | 129 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state type, slice width and counter-width helper.
package nsa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;

  localparam int NIB_W = 4;

  // A one-nibble build still needs a 1-bit counter.
  function automatic int cnt_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/full_adder4.sv
// 4-bit ripple-carry adder slice used as the serial datapath.
module full_adder4 (
  output logic [3:0] sum,
  output logic       c_out,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in
);

  logic [4:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that streams operands through full_adder4 one nibble per cycle.
// Optional signed-overflow output enabled by NSA_SIGNED_OVF_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NIB_W*NIBBLES-1:0]   a,
  input  logic [NIB_W*NIBBLES-1:0]   b,
  input  logic                       c_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NIB_W*NIBBLES-1:0]   sum,
  output logic                       c_out
`ifdef NSA_SIGNED_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  nsa_state_t  state_q;
  logic [W-1:0]  a_sh_q, b_sh_q, s_sh_q, s_sh_d;
  logic [W-1:0]  sum_q;
  logic          carry_q, c_out_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q, out_valid_q;

  logic [NIB_W-1:0] fa_sum;
  logic             fa_cout;

  full_adder4 u_fa (
    .sum   (fa_sum),
    .c_out (fa_cout),
    .a     (a_sh_q[NIB_W-1:0]),
    .b     (b_sh_q[NIB_W-1:0]),
    .c_in  (carry_q)
  );

  // New sum nibble enters at the MSB end so the LSB nibble lands at bit 0.
  if (NIBBLES == 1) begin : g_one
    assign s_sh_d = fa_sum;
  end else begin : g_multi
    assign s_sh_d = {fa_sum, s_sh_q[W-1:NIB_W]};
  end

`ifdef NSA_SIGNED_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      s_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef NSA_SIGNED_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            carry_q    <= c_in;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
`ifdef NSA_SIGNED_OVF_EN
            a_msb_q    <= a[W-1];
            b_msb_q    <= b[W-1];
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> NIB_W;
          b_sh_q  <= b_sh_q >> NIB_W;
          s_sh_q  <= s_sh_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q       <= s_sh_d;
            c_out_q     <= fa_cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef NSA_SIGNED_OVF_EN
            ovf_q       <= (a_msb_q == b_msb_q) && (s_sh_d[W-1] != a_msb_q);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef NSA_SIGNED_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4); covers ovf when NSA_SIGNED_OVF_EN is set.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef NSA_SIGNED_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;
  int lat;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef NSA_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one operand set at a negedge; returns on the negedge after the accept edge.
  task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_before_start", in_ready, 1);
    in_valid = 1'b1; a = av; b = bv; c_in = cv;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    while (!out_valid && l < 100) begin @(negedge clk); l++; end
    chk("out_valid_seen", out_valid, 1);
  endtask

  // Handshake with out_ready=1 and confirm the return to IDLE.
  task automatic take(input logic [W-1:0] exp_sum);
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_dropped", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("sum_retained", sum, exp_sum);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_low_until_edge", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    // Basic add with latency check
    out_ready = 1'b1;
    start(16'h1234, 16'h4321, 1'b0);
    wait_done(lat);
    chk("lat_1234", lat, NIBBLES);
    chk("sum_1234", sum, 16'h5555);
    chk("cout_1234", c_out, 0);
    chk("in_ready_done", in_ready, 0);
`ifdef NSA_SIGNED_OVF_EN
    chk("ovf_1234", ovf, 0);
`endif
    take(16'h5555);

    start(16'hFFFF, 16'h0001, 1'b0);
    wait_done(lat);
    chk("sum_ffff", sum, 16'h0000);
    chk("cout_ffff", c_out, 1);
    take(16'h0000);

    start(16'hA5A5, 16'h5A5A, 1'b1);
    wait_done(lat);
    chk("sum_a5a5", sum, 16'h0000);
    chk("cout_a5a5", c_out, 1);
    take(16'h0000);

`ifdef NSA_SIGNED_OVF_EN
    start(16'h7FFF, 16'h0001, 1'b0);
    wait_done(lat);
    chk("sum_7fff", sum, 16'h8000);
    chk("ovf_7fff", ovf, 1);
    chk("cout_7fff", c_out, 0);
    take(16'h8000);
`endif

    // Backpressure, with stray in_valid pulses during RUN and DONE
    out_ready = 1'b0;
    start(16'h0F0F, 16'h0101, 1'b0);
    in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, 16'h1010);
      chk("bp_cout", c_out, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    take(16'h1010);

    // Asynchronous reset mid-RUN at cnt=2
    out_ready = 1'b0;
    start(16'h00FF, 16'h0001, 1'b0);
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", c_out, 0);
    chk("abort_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready_back", in_ready, 1);
    chk("abort_no_result", out_valid, 0);
    out_ready = 1'b1;
    start(16'h0003, 16'h0004, 1'b0);
    wait_done(lat);
    chk("sum_3p4", sum, 16'h0007);
    chk("cout_3p4", c_out, 0);
    take(16'h0007);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h8000; b = 16'h8000; c_in = 1'b0;
    @(negedge clk);
    chk("b2b_first_accepted", in_ready, 0);
    a = 16'h1234; b = 16'h0001;
    wait_done(lat);
    chk("b2b_sum1", sum, 16'h0000);
    chk("b2b_cout1", c_out, 1);
    @(negedge clk);
    chk("b2b_idle_out_valid", out_valid, 0);
    chk("b2b_idle_in_ready", in_ready, 1);
    @(negedge clk);
    chk("b2b_second_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_done(lat);
    chk("b2b_lat2", lat, NIBBLES);
    chk("b2b_sum2", sum, 16'h1235);
    chk("b2b_cout2", c_out, 0);
    take(16'h1235);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
